// File: rtl/mmr_timer_bank.sv
// mmr_timer_bank: a bank of N_CH memory-mapped timer/PWM channels.
// Channel c owns word indices 4c..4c+3 (CTRL, TOP, CMP, COUNT), and the
// shared STATUS word is at index 4*N_CH. Reads are combinational from addr.
module mmr_timer_bank #(
   parameter int N_CH  = 4,
   parameter int CNT_W = 32,
   parameter int PRE_W = 8
) (
   input  logic              clk,
   input  logic              rstb,
   input  logic              sel,
   input  logic [31:0]       addr,
   input  logic              wr_ena,
   input  logic [31:0]       wr_data,
   output logic [31:0]       rd_data,
   output logic [N_CH-1:0]   ch_out,
   output logic [N_CH-1:0]   ch_irq,
   output logic              irq
);

   localparam int AW = $clog2(4*N_CH+1);

   logic [AW-1:0]      w_idx;
   logic               w_wr;
   logic               w_wr_status;
   logic [2*N_CH-1:0]  w_status_bits;
   logic [31:0]        w_rd_ctrl  [N_CH];
   logic [31:0]        w_rd_top   [N_CH];
   logic [31:0]        w_rd_cmp   [N_CH];
   logic [31:0]        w_rd_count [N_CH];
   logic               w_unused;

   assign w_idx       = addr[AW+1:2];
   assign w_wr        = sel & wr_ena;
   assign w_wr_status = w_wr & (w_idx == AW'(4*N_CH));
   // Address bits outside the word index carry no meaning for this bank.
   assign w_unused    = ^{addr[31:AW+2], addr[1:0]};

   genvar gi;
   generate
      for (gi = 0; gi < N_CH; gi++) begin : g_ch
         logic               r_en, r_oneshot, r_irq_en, r_wrap, r_match;
         logic [PRE_W-1:0]   r_pre, r_pcnt;
         logic [CNT_W-1:0]   r_top, r_cmp, r_count;
         logic               w_hit, w_wr_ctrl, w_wr_top, w_wr_cmp, w_wr_count;
         logic               w_step, w_at_top, w_flag_step, w_set_wrap, w_set_match;
         logic [CNT_W-1:0]   w_count_nxt;

         assign w_hit       = w_wr & (w_idx[AW-1:2] == (AW-2)'(gi));
         assign w_wr_ctrl   = w_hit & (w_idx[1:0] == 2'd0);
         assign w_wr_top    = w_hit & (w_idx[1:0] == 2'd1);
         assign w_wr_cmp    = w_hit & (w_idx[1:0] == 2'd2);
         assign w_wr_count  = w_hit & (w_idx[1:0] == 2'd3);

         assign w_step      = r_en & (r_pcnt == r_pre);
         assign w_at_top    = (r_count == r_top);
         // Plain increment rolls over at 2^CNT_W when TOP was lowered below count.
         assign w_count_nxt = w_at_top ? '0 : r_count + CNT_W'(1);
         // A software COUNT load in the same cycle swallows the step's flags.
         assign w_flag_step = w_step & ~w_wr_count;
         assign w_set_wrap  = w_flag_step & w_at_top;
         assign w_set_match = w_flag_step & (w_count_nxt == r_cmp);

         // Prescaler: restarts on CTRL/COUNT writes, idles at 0 while disabled.
         always_ff @(posedge clk or negedge rstb) begin
            if (!rstb)                       r_pcnt <= '0;
            else if (w_wr_ctrl | w_wr_count) r_pcnt <= '0;
            else if (!r_en || w_step)        r_pcnt <= '0;
            else                             r_pcnt <= r_pcnt + PRE_W'(1);
         end

         // Control fields; a one-shot wrap drops EN unless software writes CTRL.
         always_ff @(posedge clk or negedge rstb) begin
            if (!rstb) begin
               r_en      <= 1'b0;
               r_oneshot <= 1'b0;
               r_irq_en  <= 1'b0;
               r_pre     <= '0;
            end else if (w_wr_ctrl) begin
               r_en      <= wr_data[0];
               r_oneshot <= wr_data[1];
               r_irq_en  <= wr_data[2];
               r_pre     <= wr_data[8 +: PRE_W];
            end else if (w_step && w_at_top && r_oneshot) begin
               r_en      <= 1'b0;
            end
         end

         // Period and compare registers, written by software only.
         always_ff @(posedge clk or negedge rstb) begin
            if (!rstb) begin
               r_top <= '0;
               r_cmp <= '0;
            end else begin
               if (w_wr_top) r_top <= wr_data[CNT_W-1:0];
               if (w_wr_cmp) r_cmp <= wr_data[CNT_W-1:0];
            end
         end

         // Counter: software load has priority over a prescaler step.
         always_ff @(posedge clk or negedge rstb) begin
            if (!rstb)           r_count <= '0;
            else if (w_wr_count) r_count <= wr_data[CNT_W-1:0];
            else if (w_step)     r_count <= w_count_nxt;
         end

         // Sticky flags: a hardware set beats a simultaneous write-1-to-clear.
         always_ff @(posedge clk or negedge rstb) begin
            if (!rstb) begin
               r_wrap  <= 1'b0;
               r_match <= 1'b0;
            end else begin
               if (w_set_wrap)                            r_wrap  <= 1'b1;
               else if (w_wr_status && wr_data[2*gi])     r_wrap  <= 1'b0;
               if (w_set_match)                           r_match <= 1'b1;
               else if (w_wr_status && wr_data[2*gi+1])   r_match <= 1'b0;
            end
         end

         assign ch_out[gi]            = r_en & (r_count < r_cmp);
         assign ch_irq[gi]            = r_irq_en & (r_wrap | r_match);
         assign w_status_bits[2*gi]   = r_wrap;
         assign w_status_bits[2*gi+1] = r_match;
         assign w_rd_ctrl[gi]         = 32'({r_pre, 5'b0, r_irq_en, r_oneshot, r_en});
         assign w_rd_top[gi]          = 32'(r_top);
         assign w_rd_cmp[gi]          = 32'(r_cmp);
         assign w_rd_count[gi]        = 32'(r_count);
      end
   endgenerate

   assign irq = |ch_irq;

   // Read mux: channel words, then STATUS; unmapped indices and sel=0 read 0.
   always_comb begin
      rd_data = '0;
      if (sel) begin
         if (w_idx == AW'(4*N_CH)) begin
            rd_data = 32'(w_status_bits);
         end else begin
            for (int c = 0; c < N_CH; c++) begin
               if (w_idx[AW-1:2] == (AW-2)'(c)) begin
                  case (w_idx[1:0])
                     2'd0:    rd_data = w_rd_ctrl[c];
                     2'd1:    rd_data = w_rd_top[c];
                     2'd2:    rd_data = w_rd_cmp[c];
                     default: rd_data = w_rd_count[c];
                  endcase
               end
            end
         end
      end
   end

endmodule

// File: doc/mmr_timer_bank.md
Name: mmr_timer_bank

Overview:
- Parametrised bank of N_CH memory-mapped timer/PWM channels.
- Successor to the single free-running 1 kHz/10 kHz timer MMRs and the fixed LED PWMs.
- Each channel has a prescaler, programmable period (TOP), compare value, periodic or one-shot mode, and sticky write-1-to-clear flags.
- Sits in the MMU behind one bank decode; core reads and writes use the same addr/wr_ena/wr_data path as the other MMRs.

Parameters:
- N_CH, 4, number of channels (1..16).
- CNT_W, 32, counter/TOP/CMP width (1..32); narrower values are zero-extended on read and truncated on write.
- PRE_W, 8, prescaler width.

Ports:
- clk  in  1  system clock.
- rstb  in  1  reset, asynchronous, active-low.
- sel  in  1  core access targets this bank (bank decode done by MMU).
- addr  in  32  core byte address; word index = addr[$clog2(4*N_CH+1)+1:2].
- wr_ena  in  1  core write strobe.
- wr_data  in  32  core write data.
- rd_data  out  32  read data, combinational from addr; 0 when sel=0.
- ch_out  out  N_CH  per-channel PWM output.
- ch_irq  out  N_CH  per-channel interrupt request.
- irq  out  1  OR of ch_irq.

Behaviour:
Register map (word index w); channel c owns w=4c..4c+3:
- 4c+0 CTRL: bit0 EN, bit1 ONESHOT, bit2 IRQ_EN, bits[8+PRE_W-1:8] PRESCALE. Other bits read 0.
- 4c+1 TOP: counter period is TOP+1 steps.
- 4c+2 CMP: compare value.
- 4c+3 COUNT: read gives live count; write loads the counter.
- 4*N_CH STATUS: bit 2c = WRAP_c, bit 2c+1 = MATCH_c. Write-1-to-clear; writing 0 has no effect.
- Any other index reads 0 and ignores writes. All writes require sel & wr_ena.

Reset (rstb low, asynchronous):
- All CTRL/TOP/CMP/COUNT/prescaler/flag state = 0.
- ch_out=0, ch_irq=0, irq=0. Effective immediately, without waiting for a clock edge.

Prescaler, per channel:
- pcnt (PRE_W bits).
- While EN=1: each clk, if pcnt==PRESCALE then pcnt<=0 and step=1; else pcnt<=pcnt+1.
- A step occurs every PRESCALE+1 clocks.
- EN=0: pcnt held at 0 and count holds.

Step:
- If count==TOP: count<=0 and WRAP set. If ONESHOT=1, EN is cleared in the same cycle.
- Otherwise count<=count+1.
- MATCH is set when a step makes the new count equal CMP. This includes wrapping to 0 when CMP==0.
- TOP=0: count stays 0; WRAP (and MATCH if CMP==0) is set on every step.

Outputs:
- ch_out[c] = EN & (count < CMP), derived from registered state only. CMP=0 gives always 0; CMP>TOP gives always 1 while enabled.
- ch_irq[c] = IRQ_EN & (WRAP_c | MATCH_c).
- irq = |ch_irq.

Write timing and priority:
- Written values are visible on rd_data and in the counting logic in the next cycle.
- Writing CTRL or COUNT forces pcnt<=0.
- A COUNT write in the same cycle as a step: the write wins and that step sets no flags.
- A CTRL write clearing EN in the same cycle as a step: the step still completes, including flags.
- A STATUS W1C in the same cycle as a hardware flag set: set wins, flag stays 1.
- Changing TOP below the current count: the counter continues incrementing, wraps at 2^CNT_W to 0, and sets no WRAP at that rollover. Software must reload COUNT.
- Reset asserted mid-operation overrides everything; counting resumes only after software re-enables.

Test Plan:
1. Reset: run ch0 enabled, then drop rstb between clock edges -> ch_out, irq, rd_data(COUNT) read 0 before the next edge; after release, all registers read 0.
2. Periodic: ch0 TOP=3, PRESCALE=0, IRQ_EN=1, EN=1 -> COUNT sequence 0,1,2,3,0,1. WRAP_0 and irq assert in the cycle after 3->0. STATUS write 0x1 clears WRAP_0 and irq next cycle.
3. Prescale: ch1 TOP=10, PRESCALE=2 -> COUNT increments exactly every 3 clocks; 9 clocks after enable, COUNT=3.
4. One-shot: ch2 TOP=2, ONESHOT=1, EN=1 -> after 0,1,2,0, CTRL bit0 reads 0, COUNT holds 0 indefinitely, WRAP_2=1.
5. PWM: ch3 TOP=9, CMP=3 -> ch_out[3] high for 3 of every 10 steps. CMP=0 gives constant 0; CMP=12 gives constant 1.
6. Races: issue STATUS W1C on the exact cycle WRAP_0 sets -> WRAP_0 reads 1. Write COUNT=7 on a step cycle where count==TOP -> COUNT reads 7 and WRAP unchanged.
